// File: rtl/regfile_pkg.sv
// regfile_pkg: parameter defaults and data/address types for regfile_sb
package regfile_pkg;
    localparam int W_DEF  = 8;
    localparam int A_DEF  = 4;
    localparam int NR_DEF = 2;
    typedef logic [A_DEF-1:0] reg_addr_t;
    typedef logic [W_DEF-1:0] reg_data_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits for outstanding loads plus the WAW diagnostic flag
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int A     = A_DEF,
    parameter int ZERO0 = 0
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          SbSet,
    input  logic [A-1:0]  SbAddr,
    input  logic          WrEn1,
    input  logic [A-1:0]  Waddr1,
    input  logic          WrEn0,
    input  logic [A-1:0]  Waddr0,
    output logic [2**A-1:0] Busy,
    output logic          WawErr
);
    localparam bit Z = ZERO0 != 0;
    logic [2**A-1:0] busy_nxt;
    // set is applied after clear so a back-to-back load to the same register stays busy
    always_comb begin
        busy_nxt = Busy;
        if (WrEn1) busy_nxt[Waddr1] = 1'b0;
        if (SbSet && !(Z && SbAddr == '0)) busy_nxt[SbAddr] = 1'b1;
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Busy   <= '0;
            WawErr <= 1'b0;
        end else begin
            Busy   <= busy_nxt;
            WawErr <= WrEn0 & Busy[Waddr0] & ~(WrEn1 & (Waddr1 == Waddr0));
        end
    end
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: two-write-port register file with load scoreboard
// Optional same-cycle write-to-read bypass enabled by macro REGFILE_SB_BYPASS_EN.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int A     = A_DEF,
    parameter int NR    = NR_DEF,
    parameter int ZERO0 = 0
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic [NR*A-1:0] Raddr,
    output logic [NR*W-1:0] DataOut,
    output logic [NR-1:0]   RdReady,
    input  logic            WrEn0,
    input  logic [A-1:0]    Waddr0,
    input  logic [W-1:0]    WrData0,
    input  logic            WrEn1,
    input  logic [A-1:0]    Waddr1,
    input  logic [W-1:0]    WrData1,
    input  logic            SbSet,
    input  logic [A-1:0]    SbAddr,
    output logic [2**A-1:0] Busy,
    output logic            WawErr
);
    localparam bit Z = ZERO0 != 0;
    logic [W-1:0] mem [2**A];
    logic we0, we1;
    assign we0 = WrEn0 && !(Z && Waddr0 == '0);
    assign we1 = WrEn1 && !(Z && Waddr1 == '0);
    // port 0 is written last so the younger ALU result wins an address collision
    always_ff @(posedge Clk) begin
        if (Reset) begin
            mem <= '{default: '0};
        end else begin
            if (we1) mem[Waddr1] <= WrData1;
            if (we0) mem[Waddr0] <= WrData0;
        end
    end
    regfile_scoreboard #(.A(A), .ZERO0(ZERO0)) u_sb (
        .Clk    (Clk),
        .Reset  (Reset),
        .SbSet  (SbSet),
        .SbAddr (SbAddr),
        .WrEn1  (WrEn1),
        .Waddr1 (Waddr1),
        .WrEn0  (WrEn0),
        .Waddr0 (Waddr0),
        .Busy   (Busy),
        .WawErr (WawErr)
    );
    for (genvar g = 0; g < NR; g++) begin : g_rd
        logic [A-1:0] ra;
        logic [W-1:0] rd;
        logic         rdy;
        logic         force0;
        assign ra = Raddr[g*A +: A];
`ifdef REGFILE_SB_BYPASS_EN
        assign rd  = (WrEn0 && Waddr0 == ra) ? WrData0 : (WrEn1 && Waddr1 == ra) ? WrData1 : mem[ra];
        assign rdy = !Busy[ra] || (WrEn1 && Waddr1 == ra);
`else
        assign rd  = mem[ra];
        assign rdy = !Busy[ra];
`endif
        // reset and the hardwired r0 mask everything, bypass included
        assign force0 = Reset || (Z && ra == '0);
        assign DataOut[g*W +: W] = force0 ? '0 : rd;
        assign RdReady[g] = force0 || rdy;
    end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed and randomized checks of regfile_sb, ZERO0=0 and ZERO0=1 instances side by side
module tb_regfile_sb;
    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [7:0]  Raddr = '0;
    logic        WrEn0 = 1'b0, WrEn1 = 1'b0, SbSet = 1'b0;
    logic [3:0]  Waddr0 = '0, Waddr1 = '0, SbAddr = '0;
    logic [7:0]  WrData0 = '0, WrData1 = '0;
    logic [15:0] dout [2];
    logic [1:0]  rdy [2];
    logic [15:0] busy [2];
    logic        waw [2];
    int total = 0, bad = 0;

    // reference state: register contents, busy set, last WAW flag, per instance
    logic [7:0]  mr [2][16];
    logic [15:0] mb [2];
    logic        mw [2];

    always #5 Clk = ~Clk;

    regfile_sb #(.W(8), .A(4), .NR(2), .ZERO0(0)) dut (
        .Clk(Clk), .Reset(Reset), .Raddr(Raddr), .DataOut(dout[0]), .RdReady(rdy[0]),
        .WrEn0(WrEn0), .Waddr0(Waddr0), .WrData0(WrData0),
        .WrEn1(WrEn1), .Waddr1(Waddr1), .WrData1(WrData1),
        .SbSet(SbSet), .SbAddr(SbAddr), .Busy(busy[0]), .WawErr(waw[0])
    );
    regfile_sb #(.W(8), .A(4), .NR(2), .ZERO0(1)) dutz (
        .Clk(Clk), .Reset(Reset), .Raddr(Raddr), .DataOut(dout[1]), .RdReady(rdy[1]),
        .WrEn0(WrEn0), .Waddr0(Waddr0), .WrData0(WrData0),
        .WrEn1(WrEn1), .Waddr1(Waddr1), .WrData1(WrData1),
        .SbSet(SbSet), .SbAddr(SbAddr), .Busy(busy[1]), .WawErr(waw[1])
    );

    function automatic logic [7:0] exp_rd(int k, logic [3:0] a);
        logic [7:0] d;
        d = mr[k][a];
`ifdef REGFILE_SB_BYPASS_EN
        if (WrEn1 && Waddr1 == a) d = WrData1;
        if (WrEn0 && Waddr0 == a) d = WrData0;
`endif
        if (Reset || (k == 1 && a == 4'd0)) d = 8'h00;
        return d;
    endfunction

    function automatic logic exp_rdy(int k, logic [3:0] a);
        logic r;
        r = !mb[k][a];
`ifdef REGFILE_SB_BYPASS_EN
        if (WrEn1 && Waddr1 == a) r = 1'b1;
`endif
        if (Reset || (k == 1 && a == 4'd0)) r = 1'b1;
        return r;
    endfunction

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (Reset) begin
                for (int i = 0; i < 16; i++) mr[k][i] = 8'h00;
                mb[k] = '0;
                mw[k] = 1'b0;
            end else begin
                mw[k] = WrEn0 && mb[k][Waddr0] && !(WrEn1 && Waddr1 == Waddr0);
                if (WrEn1 && !(k == 1 && Waddr1 == 4'd0)) mr[k][Waddr1] = WrData1;
                if (WrEn0 && !(k == 1 && Waddr0 == 4'd0)) mr[k][Waddr0] = WrData0;
                if (WrEn1) mb[k][Waddr1] = 1'b0;
                if (SbSet && !(k == 1 && SbAddr == 4'd0)) mb[k][SbAddr] = 1'b1;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        WrEn0 = 1'b0; WrEn1 = 1'b0; SbSet = 1'b0; Reset = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        WrEn0 = 1'b1; Waddr0 = 4'd1; WrData0 = 8'h99;
        WrEn1 = 1'b1; Waddr1 = 4'd2; WrData1 = 8'h66;
        SbSet = 1'b1; SbAddr = 4'd3;
        tick();
        idle();
        Reset = 1'b1;
        Raddr = {4'd2, 4'd1};
        #1;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (dout[k] !== 16'h0000 || rdy[k] !== 2'b11) begin
                bad++;
                $display("FAIL reset_during k=%0d dout=%h rdy=%b want 0000/11", k, dout[k], rdy[k]);
            end
        end
        tick();
        idle();
        for (int i = 0; i < 8; i++) begin
            Raddr = {4'(2*i+1), 4'(2*i)};
            #1;
            for (int k = 0; k < 2; k++) begin
                total++;
                if (dout[k] !== 16'h0000 || rdy[k] !== 2'b11 || busy[k] !== 16'h0000 || waw[k] !== 1'b0) begin
                    bad++;
                    $display("FAIL reset_read k=%0d addr=%h dout=%h rdy=%b busy=%h waw=%b want 0/11/0/0",
                             k, Raddr, dout[k], rdy[k], busy[k], waw[k]);
                end
            end
        end
    endtask

    task automatic test_dual_write();
        idle();
        WrEn0 = 1'b1; Waddr0 = 4'd3; WrData0 = 8'hA5;
        WrEn1 = 1'b1; Waddr1 = 4'd7; WrData1 = 8'h3C;
        tick();
        idle();
        Raddr = {4'd7, 4'd3};
        #1;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (dout[k] !== 16'h3CA5) begin
                bad++;
                $display("FAIL dual_write k=%0d dout=%h want 3ca5", k, dout[k]);
            end
        end
    endtask

    task automatic test_same_addr();
        idle();
        SbSet = 1'b1; SbAddr = 4'd5;
        tick();
        idle();
        WrEn0 = 1'b1; Waddr0 = 4'd5; WrData0 = 8'h11;
        WrEn1 = 1'b1; Waddr1 = 4'd5; WrData1 = 8'h22;
        tick();
        idle();
        Raddr = {4'd5, 4'd5};
        #1;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (dout[k] !== 16'h1111 || busy[k][5] !== 1'b0 || waw[k] !== 1'b0) begin
                bad++;
                $display("FAIL same_addr k=%0d dout=%h busy5=%b waw=%b want 1111/0/0",
                         k, dout[k], busy[k][5], waw[k]);
            end
        end
    endtask

    task automatic test_sb_set_wins();
        idle();
        SbSet = 1'b1; SbAddr = 4'd9;
        tick();
        idle();
        Raddr = {4'd9, 4'd9};
        #1;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (rdy[k] !== 2'b00) begin
                bad++;
                $display("FAIL sb_not_ready k=%0d rdy=%b want 00", k, rdy[k]);
            end
        end
        SbSet = 1'b1; SbAddr = 4'd9;
        WrEn1 = 1'b1; Waddr1 = 4'd9; WrData1 = 8'h77;
        tick();
        idle();
        #1;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (busy[k][9] !== 1'b1 || rdy[k] !== 2'b00 || dout[k] !== 16'h7777) begin
                bad++;
                $display("FAIL sb_set_wins k=%0d busy9=%b rdy=%b dout=%h want 1/00/7777",
                         k, busy[k][9], rdy[k], dout[k]);
            end
        end
        WrEn1 = 1'b1; Waddr1 = 4'd9; WrData1 = 8'h78;
        tick();
        idle();
    endtask

    task automatic test_waw();
        idle();
        SbSet = 1'b1; SbAddr = 4'd2;
        tick();
        idle();
        WrEn0 = 1'b1; Waddr0 = 4'd2; WrData0 = 8'h44;
        tick();
        idle();
        Raddr = {4'd2, 4'd2};
        #1;
        for (int k = 0; k < 2; k++) begin
            total++;
            if (waw[k] !== 1'b1 || dout[k] !== 16'h4444 || busy[k][2] !== 1'b1) begin
                bad++;
                $display("FAIL waw_set k=%0d waw=%b dout=%h busy2=%b want 1/4444/1",
                         k, waw[k], dout[k], busy[k][2]);
            end
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            total++;
            if (waw[k] !== 1'b0) begin
                bad++;
                $display("FAIL waw_pulse k=%0d waw=%b want 0", k, waw[k]);
            end
        end
        WrEn1 = 1'b1; Waddr1 = 4'd2; WrData1 = 8'h45;
        tick();
        idle();
    endtask

    task automatic test_zero0();
        idle();
        WrEn0 = 1'b1; Waddr0 = 4'd0; WrData0 = 8'hFF;
        SbSet = 1'b1; SbAddr = 4'd0;
        tick();
        idle();
        Raddr = {4'd0, 4'd0};
        #1;
        total++;
        if (dout[1] !== 16'h0000 || rdy[1] !== 2'b11 || busy[1][0] !== 1'b0) begin
            bad++;
            $display("FAIL zero0_on dout=%h rdy=%b busy0=%b want 0000/11/0", dout[1], rdy[1], busy[1][0]);
        end
        total++;
        if (dout[0] !== 16'hFFFF || rdy[0] !== 2'b00 || busy[0][0] !== 1'b1) begin
            bad++;
            $display("FAIL zero0_off dout=%h rdy=%b busy0=%b want ffff/00/1", dout[0], rdy[0], busy[0][0]);
        end
        WrEn1 = 1'b1; Waddr1 = 4'd0; WrData1 = 8'h00;
        tick();
        idle();
    endtask

    task automatic test_bypass();
        logic [15:0] want;
        idle();
        WrEn0 = 1'b1; Waddr0 = 4'd4; WrData0 = 8'h12;
        tick();
        WrData0 = 8'h5A;
        Raddr = {4'd4, 4'd4};
        #1;
`ifdef REGFILE_SB_BYPASS_EN
        want = 16'h5A5A;
`else
        want = 16'h1212;
`endif
        for (int k = 0; k < 2; k++) begin
            total++;
            if (dout[k] !== want) begin
                bad++;
                $display("FAIL bypass k=%0d dout=%h want %h", k, dout[k], want);
            end
        end
        tick();
        idle();
    endtask

    task automatic test_random();
        logic [15:0] ed;
        logic [1:0]  er;
        for (int n = 0; n < 400; n++) begin
            Reset   = ($urandom_range(0, 39) == 0);
            WrEn0   = 1'($urandom);
            WrEn1   = 1'($urandom);
            SbSet   = 1'($urandom);
            Waddr0  = 4'($urandom_range(0, 5));
            Waddr1  = 4'($urandom_range(0, 5));
            SbAddr  = 4'($urandom_range(0, 5));
            WrData0 = 8'($urandom);
            WrData1 = 8'($urandom);
            Raddr   = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))};
            #1;
            for (int k = 0; k < 2; k++) begin
                ed = {exp_rd(k, Raddr[7:4]), exp_rd(k, Raddr[3:0])};
                er = {exp_rdy(k, Raddr[7:4]), exp_rdy(k, Raddr[3:0])};
                total++;
                if (dout[k] !== ed || rdy[k] !== er || busy[k] !== mb[k] || waw[k] !== mw[k]) begin
                    bad++;
                    $display("FAIL random n=%0d k=%0d dout=%h rdy=%b busy=%h waw=%b want %h/%b/%h/%b",
                             n, k, dout[k], rdy[k], busy[k], waw[k], ed, er, mb[k], mw[k]);
                end
            end
            tick();
        end
        idle();
    endtask

    initial begin
        Reset = 1'b1;
        tick();
        tick();
        test_reset();
        test_dual_write();
        test_same_addr();
        test_sb_set_wins();
        test_waw();
        test_zero0();
        test_bypass();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
